// File: rtl/cnn_cell_mac_seq.sv
// ---------------------------------------------------------------------------
// cnn_cell_mac_seq
//
// Sequential multiply-accumulate for one cellular-neural-network cell.
// Computes  sum_k (a_k*y_k + b_k*u_k) + bias  over TAPS neighbourhood taps,
// using one tap pair (two multipliers) per clock, then either saturates the
// result to OUT_WIDTH bits or wraps it in two's complement.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : an operand set is offered
//   in_ready   : block is idle and can accept an operand set
//   a_taps     : feedback template taps, tap k at [k*WIDTH +: WIDTH], signed
//   b_taps     : control template taps, same packing, signed
//   u_taps     : input neighbourhood taps, same packing, signed
//   y_taps     : state/output neighbourhood taps, same packing, signed
//   bias       : signed bias term I
//   out_valid  : result is available and held until out_ready
//   out_ready  : consumer accepts the result
//   out_data   : signed result
//   out_sat    : result was clipped (always 0 when SATURATE=0)
// ---------------------------------------------------------------------------
module cnn_cell_mac_seq #(
   parameter int WIDTH     = 9,
   parameter int TAPS      = 9,
   parameter int OUT_WIDTH = 2*WIDTH,
   parameter int SATURATE  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TAPS*WIDTH-1:0]   a_taps,
   input  logic [TAPS*WIDTH-1:0]   b_taps,
   input  logic [TAPS*WIDTH-1:0]   u_taps,
   input  logic [TAPS*WIDTH-1:0]   y_taps,
   input  logic [WIDTH-1:0]        bias,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_WIDTH-1:0]    out_data,
   output logic                    out_sat
);

   // Accumulator is wide enough for 2*TAPS full-scale products plus bias.
   localparam int ACC_W = 2*WIDTH + $clog2(2*TAPS) + 1;
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   // Common width in which the sum and the output bounds can both be compared.
   localparam int SAT_W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS-1);
   localparam logic signed [SAT_W-1:0] MAX_V =
      {{(SAT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] MIN_V =
      {{(SAT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [TAPS*WIDTH-1:0]    aTaps_q, aTaps_d;
   logic [TAPS*WIDTH-1:0]    bTaps_q, bTaps_d;
   logic [TAPS*WIDTH-1:0]    uTaps_q, uTaps_d;
   logic [TAPS*WIDTH-1:0]    yTaps_q, yTaps_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_WIDTH-1:0]     outData_q, outData_d;
   logic                     outSat_q, outSat_d;
   logic                     outValid_q, outValid_d;

   logic signed [WIDTH-1:0]   aK, bK, uK, yK;
   logic signed [2*WIDTH-1:0] prodAY, prodBU;
   logic signed [ACC_W-1:0]   term, sum, biasExt;
   logic signed [SAT_W-1:0]   sumExt;
   logic [OUT_WIDTH-1:0]      resData;
   logic                      resSat;

   // Pick the current tap pair out of the registered operand buses and form
   // the two products for this cycle; the bias is sign-extended for loading.
   always_comb begin
      aK      = aTaps_q[int'(idx_q)*WIDTH +: WIDTH];
      bK      = bTaps_q[int'(idx_q)*WIDTH +: WIDTH];
      uK      = uTaps_q[int'(idx_q)*WIDTH +: WIDTH];
      yK      = yTaps_q[int'(idx_q)*WIDTH +: WIDTH];
      prodAY  = aK * yK;
      prodBU  = bK * uK;
      term    = ACC_W'(prodAY) + ACC_W'(prodBU);
      sum     = acc_q + term;
      biasExt = ACC_W'(signed'(bias));
   end

   // Turn the final sum into the output word: clip to the OUT_WIDTH range
   // when saturating, otherwise keep the low bits (two's-complement wrap).
   always_comb begin
      sumExt  = SAT_W'(sum);
      resData = sumExt[OUT_WIDTH-1:0];
      resSat  = 1'b0;
      if (SATURATE != 0) begin
         if (sumExt > MAX_V) begin
            resData = MAX_V[OUT_WIDTH-1:0];
            resSat  = 1'b1;
         end else if (sumExt < MIN_V) begin
            resData = MIN_V[OUT_WIDTH-1:0];
            resSat  = 1'b1;
         end
      end
   end

   // Next-state logic: accept in IDLE, walk the taps in ACCUM, and hold the
   // result in DONE until the consumer takes it. The hand-off edge only
   // returns to IDLE, so a new accept is never taken on that same edge.
   always_comb begin
      state_d    = state_q;
      aTaps_d    = aTaps_q;
      bTaps_d    = bTaps_q;
      uTaps_d    = uTaps_q;
      yTaps_d    = yTaps_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      outData_d  = outData_q;
      outSat_d   = outSat_q;
      outValid_d = outValid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               aTaps_d = a_taps;
               bTaps_d = b_taps;
               uTaps_d = u_taps;
               yTaps_d = y_taps;
               acc_d   = biasExt;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = sum;
            if (idx_q == LAST_IDX) begin
               outData_d  = resData;
               outSat_d   = resSat;
               outValid_d = 1'b1;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset wins over any accept or hand-off on the same edge
   // and throws away an operation that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aTaps_q    <= '0;
         bTaps_q    <= '0;
         uTaps_q    <= '0;
         yTaps_q    <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         outData_q  <= '0;
         outSat_q   <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         aTaps_q    <= aTaps_d;
         bTaps_q    <= bTaps_d;
         uTaps_q    <= uTaps_d;
         yTaps_q    <= yTaps_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         outData_q  <= outData_d;
         outSat_q   <= outSat_d;
         outValid_q <= outValid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_sat   = outSat_q;

endmodule

// File: tb/tb_cnn_cell_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_cnn_cell_mac_seq
//
// Bench for cnn_cell_mac_seq. Two default-sized instances (saturating and
// wrapping) share one stimulus stream; a third instance with WIDTH=8,
// TAPS=25 is driven with random operands against a small reference model.
// ---------------------------------------------------------------------------
module tb_cnn_cell_mac_seq;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        outReady;
   logic [80:0] aBus, bBus, uBus, yBus;
   logic [8:0]  biasBus;
   logic        inReady0, outValid0, outSat0;
   logic [17:0] outData0;
   logic        inReady1, outValid1, outSat1;
   logic [17:0] outData1;

   logic         inValid2, outReady2;
   logic [199:0] a2, b2, u2, y2;
   logic [7:0]   bias2;
   logic         inReady2, outValid2, outSat2;
   logic [15:0]  outData2;

   int total;
   int bad;

   typedef struct {
      string       name;
      logic [80:0] a, b, u, y;
      logic [8:0]  bias;
      int          expSat;
      logic        expSatFlag;
      int          expWrap;
   } vec_t;

   vec_t vecs[$];

   cnn_cell_mac_seq #(.WIDTH(9), .TAPS(9), .OUT_WIDTH(18), .SATURATE(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
      .a_taps(aBus), .b_taps(bBus), .u_taps(uBus), .y_taps(yBus), .bias(biasBus),
      .out_valid(outValid0), .out_ready(outReady), .out_data(outData0), .out_sat(outSat0));

   cnn_cell_mac_seq #(.WIDTH(9), .TAPS(9), .OUT_WIDTH(18), .SATURATE(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
      .a_taps(aBus), .b_taps(bBus), .u_taps(uBus), .y_taps(yBus), .bias(biasBus),
      .out_valid(outValid1), .out_ready(outReady), .out_data(outData1), .out_sat(outSat1));

   cnn_cell_mac_seq #(.WIDTH(8), .TAPS(25), .OUT_WIDTH(16), .SATURATE(1)) u2i (
      .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
      .a_taps(a2), .b_taps(b2), .u_taps(u2), .y_taps(y2), .bias(bias2),
      .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2), .out_sat(outSat2));

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Last-resort guard so the run can never hang.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a failure line on mismatch.
   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [80:0] fillBus(input int v);
      logic [80:0] r;
      for (int k = 0; k < 9; k++) r[k*9 +: 9] = 9'(v);
      return r;
   endfunction

   function automatic logic [80:0] setTap(input logic [80:0] bus, input int k, input int v);
      logic [80:0] r;
      r = bus;
      r[k*9 +: 9] = 9'(v);
      return r;
   endfunction

   task automatic addVec(input string name, input logic [80:0] a, input logic [80:0] b,
                         input logic [80:0] u, input logic [80:0] y, input int bi,
                         input int expSat, input logic expFlag, input int expWrap);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.u = u; v.y = y; v.bias = 9'(bi);
      v.expSat = expSat; v.expSatFlag = expFlag; v.expWrap = expWrap;
      vecs.push_back(v);
   endtask

   // Offer one operand set, take the accept edge, then count cycles until
   // out_valid rises (bounded).
   task automatic applyStimulus(input vec_t v, output int lat);
      aBus = v.a; bBus = v.b; uBus = v.u; yBus = v.y; biasBus = v.bias;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      lat = 0;
      while (outValid0 !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic releaseResult();
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
   endtask

   // Reference for the 25-tap, 8-bit instance with 16-bit saturation.
   task automatic model25(input logic [199:0] a, input logic [199:0] b,
                          input logic [199:0] u, input logic [199:0] y,
                          input logic [7:0] bi, output int res, output int sat);
      int s;
      s = int'($signed(bi));
      for (int k = 0; k < 25; k++)
         s += int'($signed(a[k*8 +: 8])) * int'($signed(y[k*8 +: 8]))
            + int'($signed(b[k*8 +: 8])) * int'($signed(u[k*8 +: 8]));
      sat = 0;
      res = s;
      if (s > 32767) begin res = 32767; sat = 1; end
      else if (s < -32768) begin res = -32768; sat = 1; end
   endtask

   // Main test sequence.
   initial begin
      vec_t        v;
      vec_t        rampVec;
      logic [80:0] ta, tb, tu, ty;
      int          lat;
      int          leaks;

      total = 0; bad = 0;
      rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
      aBus = '0; bBus = '0; uBus = '0; yBus = '0; biasBus = '0;
      inValid2 = 1'b0; outReady2 = 1'b0;
      a2 = '0; b2 = '0; u2 = '0; y2 = '0; bias2 = '0;

      // Vector table: hand-computed expectations for saturating / wrapping.
      addVec("ones", fillBus(1), fillBus(0), fillBus(0), fillBus(1), 0, 9, 1'b0, 9);
      ta = '0;
      for (int k = 0; k < 9; k++) ta = setTap(ta, k, k + 1);
      addVec("ramp", ta, fillBus(-1), fillBus(3), fillBus(2), 5, 68, 1'b0, 68);
      addVec("allneg", fillBus(-256), fillBus(-256), fillBus(-256), fillBus(-256), 0,
             131071, 1'b1, -131072);
      addVec("allmax", fillBus(255), fillBus(0), fillBus(0), fillBus(255), 0,
             131071, 1'b1, 60937);
      addVec("negbig", fillBus(-256), fillBus(0), fillBus(0), fillBus(255), 0,
             -131072, 1'b1, -63232);
      addVec("biasonly", fillBus(0), fillBus(0), fillBus(0), fillBus(0), -256,
             -256, 1'b0, -256);
      ta = setTap('0, 0, 255); ty = setTap('0, 0, 255);
      tb = setTap('0, 0, 255); tu = setTap('0, 0, 255);
      ta = setTap(ta, 1, 255); ty = setTap(ty, 1, 3);
      tb = setTap(tb, 1, 1);   tu = setTap(tu, 1, 1);
      addVec("exactmax", ta, tb, tu, ty, 255, 131071, 1'b0, 131071);
      ta = setTap(ta, 2, 1); ty = setTap(ty, 2, 1);
      addVec("maxplus1", ta, tb, tu, ty, 255, 131071, 1'b1, -131072);
      ta = setTap('0, 0, -256); ty = setTap('0, 0, 255);
      tb = setTap('0, 0, -256); tu = setTap('0, 0, 255);
      ta = setTap(ta, 1, -256); ty = setTap(ty, 1, 1);
      addVec("exactmin", ta, tb, tu, ty, -256, -131072, 1'b0, -131072);
      tb = setTap(tb, 1, -1); tu = setTap(tu, 1, 1);
      addVec("minminus1", ta, tb, tu, ty, -256, -131072, 1'b1, 131071);
      rampVec = vecs[1];

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset in_ready", int'(inReady0), 1);
      checkOutput("reset out_valid", int'(outValid0), 0);
      checkOutput("reset out_data", int'(outData0), 0);
      checkOutput("reset out_sat", int'(outSat0), 0);
      checkOutput("reset wrap out_valid", int'(outValid1), 0);
      checkOutput("reset 25tap in_ready", int'(inReady2), 1);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         checkOutput({v.name, " in_ready"}, int'(inReady0), 1);
         applyStimulus(v, lat);
         checkOutput({v.name, " latency"}, lat, 9);
         checkOutput({v.name, " sat data"}, int'($signed(outData0)), v.expSat);
         checkOutput({v.name, " sat flag"}, int'(outSat0), int'(v.expSatFlag));
         checkOutput({v.name, " wrap valid"}, int'(outValid1), 1);
         checkOutput({v.name, " wrap data"}, int'($signed(outData1)), v.expWrap);
         checkOutput({v.name, " wrap flag"}, int'(outSat1), 0);
         releaseResult();
         checkOutput({v.name, " valid drop"}, int'(outValid0), 0);
         checkOutput({v.name, " back idle"}, int'(inReady0), 1);
      end

      // Back-pressure: result must hold while inputs are toggled.
      applyStimulus(rampVec, lat);
      checkOutput("hold latency", lat, 9);
      for (int c = 0; c < 5; c++) begin
         inValid = ~inValid;
         aBus = {$urandom, $urandom, $urandom};
         biasBus = 9'($urandom);
         @(posedge clk); #1;
         checkOutput("hold data", int'($signed(outData0)), 68);
         checkOutput("hold valid", int'(outValid0), 1);
         checkOutput("hold in_ready", int'(inReady0), 0);
      end
      inValid = 1'b1;
      releaseResult();
      inValid = 1'b0;
      checkOutput("handoff valid drop", int'(outValid0), 0);
      checkOutput("handoff no accept", int'(inReady0), 1);

      // Reset in the middle of accumulation, at tap index 4.
      applyStimulus(vecs[0], lat);
      releaseResult();
      aBus = rampVec.a; bBus = rampVec.b; uBus = rampVec.u;
      yBus = rampVec.y; biasBus = rampVec.bias;
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midreset out_valid", int'(outValid0), 0);
      checkOutput("midreset out_data", int'(outData0), 0);
      checkOutput("midreset in_ready", int'(inReady0), 1);
      leaks = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (outValid0 !== 1'b0) leaks++;
      end
      checkOutput("midreset no result", leaks, 0);
      applyStimulus(rampVec, lat);
      checkOutput("post reset latency", lat, 9);
      checkOutput("post reset data", int'($signed(outData0)), 68);
      releaseResult();

      // Random 25-tap transactions with random consumer stalls.
      for (int t = 0; t < 1000; t++) begin
         int expRes, expSat, lat2, stall;
         for (int k = 0; k < 25; k++) begin
            a2[k*8 +: 8] = 8'($urandom);
            b2[k*8 +: 8] = 8'($urandom);
            u2[k*8 +: 8] = 8'($urandom);
            y2[k*8 +: 8] = 8'($urandom);
         end
         bias2 = 8'($urandom);
         model25(a2, b2, u2, y2, bias2, expRes, expSat);
         checkOutput("rand in_ready", int'(inReady2), 1);
         inValid2 = 1'b1;
         @(posedge clk); #1;
         inValid2 = 1'b0;
         lat2 = 0;
         while (outValid2 !== 1'b1 && lat2 < 100) begin
            @(posedge clk); #1;
            lat2++;
         end
         checkOutput("rand latency", lat2, 25);
         stall = $urandom_range(0, 3);
         repeat (stall) @(posedge clk);
         #1;
         checkOutput("rand valid held", int'(outValid2), 1);
         checkOutput("rand data", int'($signed(outData2)), expRes);
         checkOutput("rand sat", int'(outSat2), expSat);
         outReady2 = 1'b1;
         @(posedge clk); #1;
         outReady2 = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
